// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider width, FSM encoding and DivAns field layout.
// The Hi/Lo register stage slices DivAns with the HI_/LO_ offsets below.
package alu_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_CNT_W = $clog2(DIV_WIDTH + 1);

  localparam int HI_MSB = 2 * DIV_WIDTH - 1;
  localparam int HI_LSB = DIV_WIDTH;
  localparam int LO_MSB = DIV_WIDTH - 1;
  localparam int LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the remainder,
// then subtract the divisor if it fits. Purely combinational, no flow control.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;
  logic             w_ge;

  // The compare needs the extra bit; the difference always fits in WIDTH bits
  // because it is strictly smaller than the divisor.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_ge    = (w_shift >= {1'b0, i_divisor});
  assign w_diff  = w_shift[WIDTH-1:0] - i_divisor;

  assign o_rem = w_ge ? w_diff : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_divider.sv
// Sequential shift-subtract divider, WIDTH+1 cycles start-to-done, start ignored while busy.
// Define SEQ_DIVIDER_SIGNED_EN for two's-complement operands (sign fix on the final write).
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_zero,
  output logic [2*WIDTH-1:0]   DivAns
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_t         r_state;
  div_state_t         w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvsr;
  logic [2*WIDTH-1:0] r_ans;
  logic               r_div_zero;

  logic               w_accept;
  logic               w_last;
  logic [WIDTH-1:0]   w_rem_step;
  logic [WIDTH-1:0]   w_quo_step;
  logic [WIDTH-1:0]   w_dvnd_load;
  logic [WIDTH-1:0]   w_dvsr_load;
  logic [2*WIDTH-1:0] w_ans_next;

  assign w_accept = start && ((r_state == IDLE) || (r_state == DONE));
  assign w_last   = (r_state == RUN) && (r_cnt == CNT_W'(1));

  div_step #(.WIDTH(WIDTH)) u_step (
    .i_rem     (r_rem),
    .i_quo     (r_quo),
    .i_divisor (r_dvsr),
    .o_rem     (w_rem_step),
    .o_quo     (w_quo_step)
  );

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_dvnd;

  // Magnitudes are divided; -2^(WIDTH-1) maps onto itself, which is the correct unsigned magnitude.
  assign w_dvnd_load = dividend[WIDTH-1] ? -dividend : dividend;
  assign w_dvsr_load = divisor[WIDTH-1]  ? -divisor  : divisor;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dvnd  <= '0;
    end else if (w_accept) begin
      r_neg_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      r_neg_r <= dividend[WIDTH-1];
      r_dvnd  <= dividend;
    end
  end

  always_comb begin
    w_ans_next = {w_rem_step, w_quo_step};
    if (r_dvsr == '0) begin
      w_ans_next = {r_dvnd, {WIDTH{1'b1}}};
    end else begin
      w_ans_next = {(r_neg_r ? -w_rem_step : w_rem_step),
                    (r_neg_q ? -w_quo_step : w_quo_step)};
    end
  end
`else
  assign w_dvnd_load = dividend;
  assign w_dvsr_load = divisor;
  assign w_ans_next  = {w_rem_step, w_quo_step};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start) w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    w_state_next = start ? RUN : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // DivAns is only written on the final iteration so the Hi/Lo stage can sample it any cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= '0;
      r_rem      <= '0;
      r_quo      <= '0;
      r_dvsr     <= '0;
      r_ans      <= '0;
      r_div_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt      <= CNT_W'(WIDTH);
      r_rem      <= '0;
      r_quo      <= w_dvnd_load;
      r_dvsr     <= w_dvsr_load;
      r_div_zero <= 1'b0;
    end else if (r_state == RUN) begin
      r_cnt <= r_cnt - CNT_W'(1);
      r_rem <= w_rem_step;
      r_quo <= w_quo_step;
      if (w_last) begin
        r_ans      <= w_ans_next;
        r_div_zero <= (r_dvsr == '0);
      end
    end
  end

  assign busy     = (r_state == RUN);
  assign done     = (r_state == DONE);
  assign div_zero = r_div_zero;
  assign DivAns   = r_ans;

endmodule

// File: tb/tb_seq_divider.sv
// Randomised and directed bench for seq_divider against an arithmetic reference model.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int W = DIV_WIDTH;

  logic           clk = 1'b0;
  logic           reset;
  logic           start;
  logic [W-1:0]   dividend;
  logic [W-1:0]   divisor;
  logic           busy;
  logic           done;
  logic           div_zero;
  logic [2*W-1:0] DivAns;

  int checks   = 0;
  int failures = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .DivAns   (DivAns)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] q;
    logic [W-1:0] r;
    longint la, lb, lq, lr;
    la = 0; lb = 0; lq = 0; lr = 0;
    if (b == '0) begin
      q = '1;
      r = a;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      la = longint'($signed(a));
      lb = longint'($signed(b));
      lq = la / lb;
      lr = la % lb;
      q  = W'(lq);
      r  = W'(lr);
`else
      q = a / b;
      r = a % b;
`endif
    end
    return {r, q};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    tick();
    start    = 1'b0;
  endtask

  task automatic wait_done(output int busy_cyc, output int total);
    busy_cyc = 0;
    total    = 0;
    while (!done && total < 100) begin
      if (busy) busy_cyc++;
      tick();
      total++;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) tick();
    checks++; if ({busy, done, div_zero} !== 3'b000) begin failures++;
      $display("FAIL reset_flags: got %b expected 000", {busy, done, div_zero}); end
    checks++; if (DivAns !== '0) begin failures++;
      $display("FAIL reset_divans: got %h expected 0", DivAns); end
    reset = 1'b0;
    repeat (2) tick();
    checks++; if ({busy, done} !== 2'b00) begin failures++;
      $display("FAIL idle_no_start: got %b expected 00", {busy, done}); end
  endtask

  task automatic test_basic();
    int bc, t;
    launch(32'd100, 32'd7);
    wait_done(bc, t);
    checks++; if (bc != 32) begin failures++;
      $display("FAIL basic_busy_cycles: got %0d expected 32", bc); end
    checks++; if (done !== 1'b1 || t != 32) begin failures++;
      $display("FAIL basic_done_latency: done=%b after %0d edges expected 1 after 32", done, t); end
    checks++; if (DivAns !== {32'd2, 32'd14}) begin failures++;
      $display("FAIL basic_divans: got %h expected %h", DivAns, {32'd2, 32'd14}); end
    checks++; if (div_zero !== 1'b0) begin failures++;
      $display("FAIL basic_div_zero: got %b expected 0", div_zero); end
    tick();
    checks++; if ({busy, done} !== 2'b00) begin failures++;
      $display("FAIL basic_done_pulse: got busy,done=%b expected 00", {busy, done}); end
    checks++; if (DivAns[HI_MSB:HI_LSB] !== 32'd2 || DivAns[LO_MSB:LO_LSB] !== 32'd14) begin failures++;
      $display("FAIL basic_hold: got %h expected %h", DivAns, {32'd2, 32'd14}); end
  endtask

  task automatic test_div_zero();
    int bc, t;
    launch(32'h12345678, 32'd0);
    wait_done(bc, t);
    checks++; if (done !== 1'b1 || t != 32) begin failures++;
      $display("FAIL dz_latency: done=%b after %0d edges expected 1 after 32", done, t); end
    checks++; if (DivAns !== {32'h12345678, 32'hFFFFFFFF}) begin failures++;
      $display("FAIL dz_divans: got %h expected %h", DivAns, {32'h12345678, 32'hFFFFFFFF}); end
    checks++; if (div_zero !== 1'b1) begin failures++;
      $display("FAIL dz_flag: got %b expected 1", div_zero); end
    repeat (3) tick();
    checks++; if (div_zero !== 1'b1) begin failures++;
      $display("FAIL dz_flag_held: got %b expected 1", div_zero); end
  endtask

  task automatic test_start_ignored();
    int bc, t;
    launch(32'd1000, 32'd33);
    checks++; if (div_zero !== 1'b0) begin failures++;
      $display("FAIL dz_cleared_on_start: got %b expected 0", div_zero); end
    checks++; if (DivAns !== {32'h12345678, 32'hFFFFFFFF}) begin failures++;
      $display("FAIL divans_kept_on_start: got %h expected %h", DivAns, {32'h12345678, 32'hFFFFFFFF}); end
    repeat (9) tick();
    launch(32'd5, 32'd1);
    wait_done(bc, t);
    checks++; if (done !== 1'b1 || t + 10 != 32) begin failures++;
      $display("FAIL ignore_latency: done=%b after %0d edges expected 1 after 32", done, t + 10); end
    checks++; if (DivAns !== ref_div(32'd1000, 32'd33)) begin failures++;
      $display("FAIL ignore_divans: got %h expected %h", DivAns, ref_div(32'd1000, 32'd33)); end
    tick();
  endtask

  task automatic test_reset_mid_run();
    int bc, t;
    launch(32'hDEADBEEF, 32'd17);
    repeat (14) tick();
    reset = 1'b1;
    tick();
    checks++; if ({busy, done, div_zero} !== 3'b000) begin failures++;
      $display("FAIL midrst_flags: got %b expected 000", {busy, done, div_zero}); end
    checks++; if (DivAns !== '0) begin failures++;
      $display("FAIL midrst_divans: got %h expected 0", DivAns); end
    reset = 1'b0;
    repeat (3) tick();
    checks++; if ({busy, done} !== 2'b00) begin failures++;
      $display("FAIL midrst_idle: got %b expected 00", {busy, done}); end
    launch(32'd9, 32'd3);
    wait_done(bc, t);
    checks++; if (done !== 1'b1 || DivAns !== {32'd0, 32'd3}) begin failures++;
      $display("FAIL midrst_next_div: done=%b DivAns=%h expected 1 %h", done, DivAns, {32'd0, 32'd3}); end
    tick();
  endtask

  task automatic test_back_to_back();
    int bc, t;
    launch(32'd50, 32'd5);
    wait_done(bc, t);
    checks++; if (done !== 1'b1 || DivAns !== {32'd0, 32'd10}) begin failures++;
      $display("FAIL b2b_first: done=%b DivAns=%h expected 1 %h", done, DivAns, {32'd0, 32'd10}); end
    launch(32'hFFFFFFFF, 32'd1);
    checks++; if ({busy, done} !== 2'b10) begin failures++;
      $display("FAIL b2b_immediate_run: got busy,done=%b expected 10", {busy, done}); end
    wait_done(bc, t);
    checks++; if (done !== 1'b1 || t + 1 != 33) begin failures++;
      $display("FAIL b2b_spacing: done=%b %0d cycles after first done expected 33", done, t + 1); end
    checks++; if (DivAns !== {32'd0, 32'hFFFFFFFF}) begin failures++;
      $display("FAIL b2b_divans: got %h expected %h", DivAns, {32'd0, 32'hFFFFFFFF}); end
    tick();
  endtask

  task automatic test_random();
    int bc, t;
    logic [W-1:0] a, b;
    logic [2*W-1:0] exp;
    for (int i = 0; i < 40; i++) begin
      a = $urandom();
      case ($urandom_range(0, 4))
        0:       b = '0;
        1:       b = W'($urandom_range(1, 15));
        2:       b = $urandom();
        3:       b = a >> $urandom_range(0, 31);
        default: b = '1;
      endcase
      if ($urandom_range(0, 7) == 0) a = 32'h80000000;
      exp = ref_div(a, b);
      launch(a, b);
      wait_done(bc, t);
      checks++; if (done !== 1'b1 || bc != 32) begin failures++;
        $display("FAIL rand_latency[%0d]: done=%b busy=%0d expected 1 32", i, done, bc); end
      checks++; if (DivAns !== exp) begin failures++;
        $display("FAIL rand_divans[%0d]: %h/%h got %h expected %h", i, a, b, DivAns, exp); end
      checks++; if (div_zero !== (b == '0)) begin failures++;
        $display("FAIL rand_div_zero[%0d]: got %b expected %b", i, div_zero, (b == '0)); end
      // Roughly half the time the next start lands in the DONE cycle.
      if ($urandom_range(0, 1) == 0) tick();
    end
    tick();
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int bc, t;
    logic [W-1:0] av[4] = '{32'hFFFFFFF9, 32'h80000000, 32'd7,        32'hFFFFFFF8};
    logic [W-1:0] bv[4] = '{32'd2,        32'hFFFFFFFF, 32'hFFFFFFFE, 32'd0};
    logic [2*W-1:0] ev[4] = '{{32'hFFFFFFFF, 32'hFFFFFFFD}, {32'd0, 32'h80000000},
                              {32'd1, 32'hFFFFFFFD}, {32'hFFFFFFF8, 32'hFFFFFFFF}};
    for (int i = 0; i < 4; i++) begin
      launch(av[i], bv[i]);
      wait_done(bc, t);
      checks++; if (done !== 1'b1 || DivAns !== ev[i]) begin failures++;
        $display("FAIL signed[%0d]: done=%b DivAns=%h expected 1 %h", i, done, DivAns, ev[i]); end
      tick();
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_start_ignored();
    test_reset_mid_run();
    test_back_to_back();
    test_random();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
- Multi-cycle restoring divider (shift-subtract) for the ALU datapath. It sits directly upstream of the Hi/Lo register pair.
- Accepts dividend/divisor on a start pulse and iterates one quotient bit per clock.
- Presents the 64-bit packed result DivAns = {remainder, quotient}, which the Hi/Lo stage captures: Hi = remainder, Lo = quotient.

Parameters:
- WIDTH, 32, operand width; DivAns is 2*WIDTH bits; iteration count = WIDTH.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  one-cycle request; accepted only in IDLE or DONE
- dividend  input  WIDTH  numerator, sampled on accepted start
- divisor  input  WIDTH  denominator, sampled on accepted start
- busy  output  1  high while state = RUN
- done  output  1  one-cycle pulse when DivAns holds a new result
- div_zero  output  1  high with done when the divisor sampled was 0; held until next accepted start
- DivAns  output  2*WIDTH  {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}, registered

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset values: state = IDLE; busy = 0; done = 0; div_zero = 0; DivAns = 0; internal registers = 0.
  - Reset has priority over everything, including mid-RUN; the partial result is discarded.
- States: IDLE, RUN, DONE.
  - IDLE: if start, latch operands, clear rem, load counter = WIDTH, go to RUN.
  - RUN, each cycle:
    - rem_next = {rem[WIDTH-2:0], quo_shift MSB}.
    - If rem_next >= divisor (unsigned, WIDTH+1-bit compare), subtract and shift in 1; else shift in 0.
    - Decrement counter. When the counter reaches 0, go to DONE and register DivAns.
    - start is ignored in RUN; operands are not resampled.
  - DONE: done = 1 for exactly this one cycle. If start, accept it (back-to-back) and go to RUN; else go to IDLE.
- Latency: start sampled at edge N gives done high in the cycle after edge N+WIDTH (WIDTH+1 cycles of busy/done total). Throughput is one division per WIDTH+1 cycles.
- DivAns holds its value from done until the next result or reset. It is not cleared on a new start, so the Hi/Lo stage may sample it on any cycle.
- Divide by zero: no special path; the algorithm naturally yields quotient = all ones and remainder = dividend. div_zero = 1. Latency is unchanged.
- Default arithmetic is unsigned.

Optional Feature:
- Macro: SEQ_DIVIDER_SIGNED_EN.
- Defined: operands are two's complement.
  - The magnitudes are divided.
  - Quotient is negated if the operand signs differ.
  - Remainder takes the dividend's sign.
  - Sign fix is applied in the RUN→DONE register write; latency is unchanged.
  - -2^(WIDTH-1) / -1 gives quotient 0x80000000, remainder 0.
  - Divide by zero is forced to quotient all ones and remainder = dividend, regardless of sign.
- Undefined: unsigned only; no sign logic is synthesised.

Decomposition:
- Shared package alu_pkg:
  - DIV_WIDTH = 32
  - state encoding div_state_t {IDLE, RUN, DONE}
  - localparam for counter width = clog2(WIDTH+1)
  - DivAns field offsets (HI_MSB/HI_LSB, LO_MSB/LO_LSB), shared with the Hi/Lo stage
- One natural sub-module: div_step, the combinational single-iteration shift/compare/subtract cell, instantiated once inside seq_divider.

Test Plan:
- dividend = 100, divisor = 7, start pulse → busy for 32 cycles, done in cycle 33, DivAns = {32'd2, 32'd14}, div_zero = 0.
- dividend = 0x12345678, divisor = 0 → DivAns = {0x12345678, 0xFFFFFFFF}, div_zero = 1 with done.
- start = 1 pulsed at cycle 10 of RUN with new operands → ignored; result still matches the original operands at cycle 33.
- reset asserted at cycle 15 of RUN → next edge: busy = 0, done = 0, DivAns = 0, state IDLE; a subsequent 9/3 gives {0, 3}.
- start held high in the DONE cycle with 0xFFFFFFFF / 1 → done pulse for the first result, immediate RUN, second done exactly 33 cycles later with {0, 0xFFFFFFFF}.
- SEQ_DIVIDER_SIGNED_EN defined:
  - -7 / 2 → {0xFFFFFFFF, 0xFFFFFFFD}
  - 0x80000000 / 0xFFFFFFFF → {0, 0x80000000}
